// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes on the encoder
// interface and the key sequencer state encoding.
package morse_pkg;

  localparam logic [2:0] SIG_DOT    = 3'b000;
  localparam logic [2:0] SIG_DASH   = 3'b001;
  localparam logic [2:0] SIG_SPACE  = 3'b010;
  localparam logic [2:0] SIG_ENDSEQ = 3'b011;
  localparam logic [2:0] SIG_IDLE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/morse_run_counter.sv
// Run-length counter of one level: reloads 1 on a level
// change, else increments, saturating at all-ones.
// Ports: clk, reset (sync, high), level in;
//   cnt = registered run length, cnt_next = its next value.
module morse_run_counter #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             level,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next
);

  logic level_q;

  always_comb begin
    if (level != level_q)
      cnt_next = CNT_W'(1);
    else if (&cnt)
      cnt_next = cnt;
    else
      cnt_next = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      level_q <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      level_q <= level;
    end
  end

endmodule

// File: rtl/morse_key_sequencer.sv
// Morse key front end: times press/gap runs of Key, emits
// dot/dash/space/end codes and hands letters downstream.
// Ports: Clk, Reset (sync, high), Key in; Signals/SymValid
//   symbol pulse; LetterBits/LetterLen/LetterValid with
//   LetterReady handshake; Overflow sticky error.
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int DOT_MAX    = 4_000_000,
  parameter int LETTER_GAP = 8_000_000,
  parameter int WORD_GAP   = 20_000_000,
  parameter int MAX_SYM    = 5,
  parameter int CNT_W      = 25
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Key,
  output logic [2:0]         Signals,
  output logic               SymValid,
  output logic [MAX_SYM-1:0] LetterBits,
  output logic [2:0]         LetterLen,
  output logic               LetterValid,
  input  logic               LetterReady,
  output logic               Overflow
);

  state_t state, state_n;

  logic [CNT_W-1:0] cnt, cnt_next;

  logic [MAX_SYM-1:0] acc_bits;
  logic [2:0]         acc_len;

  logic       is_dash;
  logic       at_letter;
  logic       at_word;
  logic       acc_full;
  logic [2:0] sig_d;
  logic       sym_d;
  logic       append;
  logic       fin;
  logic       drop;
  logic       load;

  morse_run_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (Clk),
    .reset   (Reset),
    .level   (Key),
    .cnt     (cnt),
    .cnt_next(cnt_next)
  );

  // cnt holds the finished press length on release;
  // gap thresholds fire on the cycle the low run hits them.
  assign is_dash   = cnt >= CNT_W'(DOT_MAX);
  assign at_letter = cnt_next == CNT_W'(LETTER_GAP);
  assign at_word   = cnt_next == CNT_W'(WORD_GAP);
  assign acc_full  = acc_len == 3'(MAX_SYM);

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (Key) state_n = PRESS;
      PRESS:   if (!Key) state_n = GAP;
      GAP: begin
        if (Key)
          state_n = PRESS;
        else if (at_word)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Key=1 in GAP never reaches the threshold checks,
  // so a press always wins over a gap event.
  always_comb begin
    sig_d  = SIG_IDLE;
    sym_d  = 1'b0;
    append = 1'b0;
    fin    = 1'b0;
    unique case (state)
      PRESS: begin
        if (!Key) begin
          sym_d  = 1'b1;
          append = 1'b1;
          sig_d  = is_dash ? SIG_DASH : SIG_DOT;
        end
      end
      GAP: begin
        if (!Key && at_letter) begin
          sym_d = 1'b1;
          fin   = 1'b1;
          sig_d = SIG_SPACE;
        end else if (!Key && at_word) begin
          sym_d = 1'b1;
          sig_d = SIG_ENDSEQ;
        end
      end
      default: ;
    endcase
  end

  // A held letter not taken this cycle blocks a new one.
  assign drop = fin && LetterValid && !LetterReady;
  assign load = fin && !drop;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Signals     <= SIG_IDLE;
      SymValid    <= 1'b0;
      acc_bits    <= '0;
      acc_len     <= '0;
      LetterBits  <= '0;
      LetterLen   <= '0;
      LetterValid <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      Signals  <= sig_d;
      SymValid <= sym_d;
      if (fin) begin
        acc_bits <= '0;
        acc_len  <= '0;
      end else if (append && !acc_full) begin
        acc_bits <= acc_bits
                  | (MAX_SYM'(is_dash) << acc_len);
        acc_len  <= acc_len + 3'd1;
      end
      if ((append && acc_full) || drop)
        Overflow <= 1'b1;
      if (load) begin
        LetterBits  <= acc_bits;
        LetterLen   <= acc_len;
        LetterValid <= 1'b1;
      end else if (LetterValid && LetterReady) begin
        LetterValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Scoreboard bench for morse_key_sequencer with
// directed key patterns and hand-derived symbol timing.
module tb_morse_key_sequencer;
  import morse_pkg::*;

  localparam int DM = 4;
  localparam int LG = 8;
  localparam int WG = 16;
  localparam int MS = 5;
  localparam int CW = 25;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Key = 1'b0;
  logic          LetterReady = 1'b1;
  logic [2:0]    Signals;
  logic          SymValid;
  logic [MS-1:0] LetterBits;
  logic [2:0]    LetterLen;
  logic          LetterValid;
  logic          Overflow;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] code;
    int         at;
  } sym_t;

  typedef struct {
    logic [MS-1:0] bits;
    logic [2:0]    len;
  } let_t;

  sym_t sym_q[$];
  sym_t plan_q[$];
  let_t let_q[$];

  morse_key_sequencer #(
    .DOT_MAX   (DM),
    .LETTER_GAP(LG),
    .WORD_GAP  (WG),
    .MAX_SYM   (MS),
    .CNT_W     (CW)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Key        (Key),
    .Signals    (Signals),
    .SymValid   (SymValid),
    .LetterBits (LetterBits),
    .LetterLen  (LetterLen),
    .LetterValid(LetterValid),
    .LetterReady(LetterReady),
    .Overflow   (Overflow)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Expected symbol "off" cycles after the first cycle
  // of the next run; off = run count that triggers it.
  task automatic plan(logic [2:0] code, int off);
    sym_t s;
    s.code = code;
    s.at   = off;
    plan_q.push_back(s);
  endtask

  task automatic plan_letter(logic [MS-1:0] bits,
                             logic [2:0] len);
    let_t l;
    l.bits = bits;
    l.len  = len;
    let_q.push_back(l);
  endtask

  task automatic run(logic lvl, int n);
    sym_t s;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      if (i == 0) begin
        foreach (plan_q[j]) begin
          s.code = plan_q[j].code;
          s.at   = cyc + plan_q[j].at;
          sym_q.push_back(s);
        end
        plan_q.delete();
      end
      Key = lvl;
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_signals"}, Signals, SIG_IDLE);
    check({tag, "_symvalid"}, SymValid, 0);
    check({tag, "_lvalid"}, LetterValid, 0);
    check({tag, "_lbits"}, LetterBits, 0);
    check({tag, "_llen"}, LetterLen, 0);
    check({tag, "_ovf"}, Overflow, 0);
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    Key   = 1'b0;
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    Reset = 1'b0;
    @(negedge Clk);
    check_reset_vals("reset");
  endtask

  // Monitor: symbol pulses, letter handshakes, hold rule.
  sym_t          m_sym;
  let_t          m_let;
  logic          hold = 1'b0;
  logic [MS-1:0] prev_bits;
  logic [2:0]    prev_len;

  always @(negedge Clk) begin
    if (SymValid) begin
      if (sym_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sym_unexpected: got %b, none queued (cycle %0d)",
                 Signals, cyc);
      end else begin
        m_sym = sym_q.pop_front();
        check("sym_code", Signals, m_sym.code);
        check("sym_cycle", cyc, m_sym.at);
      end
    end
    if (hold) begin
      check("hold_valid", LetterValid, 1);
      check("hold_bits", LetterBits, prev_bits);
      check("hold_len", LetterLen, prev_len);
    end
    if (LetterValid && LetterReady) begin
      if (let_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL let_unexpected: got bits %b len %0d, none queued",
                 LetterBits, LetterLen);
      end else begin
        m_let = let_q.pop_front();
        check("let_bits", LetterBits, m_let.bits);
        check("let_len", LetterLen, m_let.len);
      end
    end
    hold      = LetterValid && !LetterReady;
    prev_bits = LetterBits;
    prev_len  = LetterLen;
  end

  initial begin
    do_reset();

    // 1: single dot, space at low 8, end at low 16
    run(1'b1, 2);
    plan(SIG_DOT, 1);
    plan(SIG_SPACE, 8);
    plan(SIG_ENDSEQ, 16);
    plan_letter(5'b00000, 3'd1);
    run(1'b0, 20);

    // 2: letter K = dash dot dash
    run(1'b1, 6);
    plan(SIG_DASH, 1);
    run(1'b0, 3);
    run(1'b1, 2);
    plan(SIG_DOT, 1);
    run(1'b0, 3);
    run(1'b1, 6);
    plan(SIG_DASH, 1);
    plan(SIG_SPACE, 8);
    plan(SIG_ENDSEQ, 16);
    plan_letter(5'b00101, 3'd3);
    run(1'b0, 20);

    // 3: press 3 dot, low 7 no space, press 4 dash
    run(1'b1, 3);
    plan(SIG_DOT, 1);
    run(1'b0, 7);
    run(1'b1, 4);
    plan(SIG_DASH, 1);
    plan(SIG_SPACE, 8);
    plan(SIG_ENDSEQ, 16);
    plan_letter(5'b00010, 3'd2);
    run(1'b0, 20);
    @(negedge Clk);
    check("t3_ovf", Overflow, 0);

    // 4: six dots in one letter
    for (int k = 0; k < 5; k++) begin
      run(1'b1, 2);
      plan(SIG_DOT, 1);
      run(1'b0, 2);
    end
    @(negedge Clk);
    check("t4_ovf_5sym", Overflow, 0);
    run(1'b1, 2);
    plan(SIG_DOT, 1);
    plan(SIG_SPACE, 8);
    plan(SIG_ENDSEQ, 16);
    plan_letter(5'b00000, 3'd5);
    run(1'b0, 20);
    @(negedge Clk);
    check("t4_ovf_set", Overflow, 1);
    run(1'b0, 10);
    @(negedge Clk);
    check("t4_ovf_sticky", Overflow, 1);

    do_reset();

    // 5: ready low, second letter dropped
    LetterReady = 1'b0;
    run(1'b1, 2);
    plan(SIG_DOT, 1);
    plan(SIG_SPACE, 8);
    plan_letter(5'b00000, 3'd1);
    run(1'b0, 10);
    @(negedge Clk);
    check("t5_lvalid_1st", LetterValid, 1);
    check("t5_ovf_1st", Overflow, 0);
    run(1'b1, 5);
    plan(SIG_DASH, 1);
    plan(SIG_SPACE, 8);
    plan(SIG_ENDSEQ, 16);
    run(1'b0, 20);
    @(negedge Clk);
    check("t5_lvalid_held", LetterValid, 1);
    check("t5_lbits_held", LetterBits, 5'b00000);
    check("t5_llen_held", LetterLen, 1);
    check("t5_ovf_drop", Overflow, 1);
    @(posedge Clk);
    #1;
    LetterReady = 1'b1;
    @(negedge Clk);
    check("t5_lvalid_acc", LetterValid, 1);
    @(negedge Clk);
    check("t5_lvalid_fall", LetterValid, 0);

    // 6: reset on cycle 3 of a press
    run(1'b1, 2);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    Key   = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    Key   = 1'b0;
    @(negedge Clk);
    check_reset_vals("t6");
    run(1'b0, 5);
    run(1'b1, 2);
    plan(SIG_DOT, 1);
    plan(SIG_SPACE, 8);
    plan(SIG_ENDSEQ, 16);
    plan_letter(5'b00000, 3'd1);
    run(1'b0, 20);
    @(negedge Clk);
    check("t6_ovf", Overflow, 0);

    run(1'b0, 4);
    @(negedge Clk);
    check("sym_left", sym_q.size(), 0);
    check("let_left", let_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
